// File: rtl/cp0_vic.sv
// Coprocessor-0 with a vectored interrupt controller: STATUS/CAUSE/EPC/EBASE plus a
// 32-entry general file, edge-latched IRQ lines with mask, fixed priority and ERET.
module cp0_vic #(
  parameter int unsigned IRQ_NUM     = 4,
  parameter logic [31:0] VEC_SPACING = 32'h20,
  parameter logic [31:0] EBASE_RST   = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         oper,
  input  logic [4:0]         addr_r,
  output logic [31:0]        data_r,
  input  logic [4:0]         addr_w,
  input  logic [31:0]        data_w,
  input  logic               ir_en,
  input  logic [IRQ_NUM-1:0] ir_in,
  input  logic [31:0]        ret_addr,
  output logic               jump_en,
  output logic [31:0]        jump_addr,
  output logic [IRQ_NUM-1:0] irq_ack
);

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ERET  = 2'b10;

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;
  localparam logic [4:0] REG_EBASE  = 5'd15;

  logic [IRQ_NUM-1:0] prev_q, prev_d, ip_q, ip_d, im_q, im_d, ack_q, ack_d;
  logic [IRQ_NUM-1:0] rise_c, req_c, win_c, w1c_c;
  logic               ie_q, ie_d, exl_q, exl_d, eret_q, eret_d, jump_en_q, jump_en_d;
  logic [4:0]         exc_q, exc_d, idx_c;
  logic [26:0]        ebase_q, ebase_d;
  logic [31:0]        epc_q, epc_d, jump_addr_q, jump_addr_d, data_r_q, data_r_d;
  logic [31:0]        status_rd_c, cause_rd_c, ebase_rd_c, rd_val_c, vec_c;
  logic               store_c, take_c, gpr_we_c;
  logic [31:0]        gpr_q [32];

  assign data_r    = data_r_q;
  assign jump_en   = jump_en_q;
  assign jump_addr = jump_addr_q;
  assign irq_ack   = ack_q;

  // Architected register read views; unimplemented bits read as zero
  always_comb begin
    status_rd_c                 = '0;
    status_rd_c[0]              = ie_q;
    status_rd_c[1]              = exl_q;
    status_rd_c[8 +: IRQ_NUM]   = im_q;
    cause_rd_c                  = '0;
    cause_rd_c[6:2]             = exc_q;
    cause_rd_c[8 +: IRQ_NUM]    = ip_q;
    ebase_rd_c                  = {ebase_q, 5'b0};
    case (addr_r)
      REG_STATUS: rd_val_c = status_rd_c;
      REG_CAUSE:  rd_val_c = cause_rd_c;
      REG_EPC:    rd_val_c = epc_q;
      REG_EBASE:  rd_val_c = ebase_rd_c;
      default:    rd_val_c = gpr_q[addr_r];
    endcase
  end

  // Edge detection, request arbitration (lowest index wins) and take decision
  always_comb begin
    rise_c = ir_in & ~prev_q;
    req_c  = ip_q & im_q;
    idx_c  = '0;
    win_c  = '0;
    for (int i = int'(IRQ_NUM) - 1; i >= 0; i--) begin
      if (req_c[i]) begin
        idx_c    = 5'(i);
        win_c    = '0;
        win_c[i] = 1'b1;
      end
    end
    // A pending ERET holds off the take so the two redirects never collide
    take_c   = ir_en & ie_q & ~exl_q & ~eret_q & (|req_c);
    vec_c    = ebase_rd_c + 32'(idx_c) * VEC_SPACING;
    store_c  = (oper == OP_STORE);
    gpr_we_c = store_c && (addr_w != REG_STATUS) && (addr_w != REG_CAUSE) &&
               (addr_w != REG_EPC) && (addr_w != REG_EBASE);
    w1c_c    = (store_c && addr_w == REG_CAUSE) ? data_w[8 +: IRQ_NUM] : '0;
  end

  // Next-state for architected state and redirect outputs
  always_comb begin
    prev_d      = ir_in;
    ie_d        = ie_q;
    exl_d       = exl_q;
    im_d        = im_q;
    exc_d       = exc_q;
    epc_d       = epc_q;
    ebase_d     = ebase_q;
    eret_d      = (oper == OP_ERET);
    data_r_d    = (oper == OP_NONE) ? rd_val_c : data_r_q;
    jump_en_d   = 1'b0;
    jump_addr_d = jump_addr_q;
    ack_d       = '0;

    if (store_c && addr_w == REG_STATUS) begin
      ie_d  = data_w[0];
      exl_d = data_w[1];
      im_d  = data_w[8 +: IRQ_NUM];
    end
    if (store_c && addr_w == REG_EPC)   epc_d   = data_w;
    if (store_c && addr_w == REG_EBASE) ebase_d = data_w[31:5];

    // A new rising edge beats both the W1C clear and the take clear
    ip_d = (ip_q & ~w1c_c & ~(take_c ? win_c : '0)) | rise_c;

    if (eret_q) begin
      exl_d       = 1'b0;
      jump_en_d   = 1'b1;
      jump_addr_d = epc_q;
    end
    if (take_c) begin
      exl_d       = 1'b1;
      exc_d       = idx_c;
      epc_d       = ret_addr;
      ack_d       = win_c;
      jump_en_d   = 1'b1;
      jump_addr_d = vec_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= '0;
      ip_q        <= '0;
      im_q        <= '0;
      ie_q        <= 1'b0;
      exl_q       <= 1'b0;
      exc_q       <= '0;
      epc_q       <= '0;
      ebase_q     <= EBASE_RST[31:5];
      eret_q      <= 1'b0;
      data_r_q    <= '0;
      jump_en_q   <= 1'b0;
      jump_addr_q <= '0;
      ack_q       <= '0;
    end else begin
      prev_q      <= prev_d;
      ip_q        <= ip_d;
      im_q        <= im_d;
      ie_q        <= ie_d;
      exl_q       <= exl_d;
      exc_q       <= exc_d;
      epc_q       <= epc_d;
      ebase_q     <= ebase_d;
      eret_q      <= eret_d;
      data_r_q    <= data_r_d;
      jump_en_q   <= jump_en_d;
      jump_addr_q <= jump_addr_d;
      ack_q       <= ack_d;
    end
  end

  // General register file is intentionally left unreset
  always_ff @(posedge clk) begin
    if (gpr_we_c) gpr_q[addr_w] <= data_w;
  end

endmodule
